out_display_driver: RTL and testbench

- Downstream consumer of the output register.
- Captures the 8-bit output value on a load strobe and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Drives a time-multiplexed 3-digit seven-segment display (hundreds/tens/ones) with leading-zero blanking.
- Replaces the direct two-hex-digit display path with a decimal readout.

---
 rtl/out_display_driver_pkg.sv | 63 ++++++
 rtl/out_display_driver_bin2bcd_seq.sv | 95 +++++++++
 rtl/out_display_driver.sv | 82 ++++++++
 tb/tb_out_display_driver.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/out_display_driver_pkg.sv
// Shared constants, FSM encoding and helper functions for the decimal display driver.
package out_display_driver_pkg;

    localparam int unsigned DIN_W   = 8;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned NDIGITS = 3;
    localparam int unsigned BCD_W   = NIB_W * NDIGITS;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned SCAN_W  = 16;
    localparam int unsigned DIG_W   = 2;
    localparam int unsigned CNT_W   = 3;

    // Segment patterns, active-high, bit0=a ... bit6=g
    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Double-dabble correction: add 3 to every nibble that is 5 or more
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < int'(NDIGITS); i++) begin
            if (v[i*NIB_W +: NIB_W] >= 4'd5) begin
                r[i*NIB_W +: NIB_W] = v[i*NIB_W +: NIB_W] + 4'd3;
            end
        end
        return r;
    endfunction

    // BCD nibble to segment pattern; codes 10-15 never occur and stay dark
    function automatic logic [SEG_W-1:0] seg_decode(input logic [NIB_W-1:0] n);
        logic [SEG_W-1:0] s;
        case (n)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/out_display_driver_bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter with a one-deep pending slot.
module bin2bcd_seq
    import out_display_driver_pkg::*;
(
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic [DIN_W-1:0] din_i,
    input  logic             ld_i,
    output logic [BCD_W-1:0] bcd_o,
    output logic             busy_o,
    output logic             done_o
);

    state_t             state_q;
    logic [DIN_W-1:0]   bin_q;
    logic [BCD_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DIN_W-1:0]   pend_q;
    logic               pend_vld_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               busy_q;
    logic               done_q;

    logic [BCD_W-1:0]       adj_d;
    logic [BCD_W+DIN_W-1:0] shift_d;

    // One double-dabble step: correct the digits, then shift {acc, bin} left
    always_comb begin
        adj_d   = add3_digits(acc_q);
        shift_d = {adj_d[BCD_W-2:0], bin_q, 1'b0};
    end

    // Conversion FSM; the display keeps the old bcd until UPDATE commits
    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            bcd_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ld_i) begin
                        bin_q   <= din_i;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ld_i) begin
                        pend_q     <= din_i;
                        pend_vld_q <= 1'b1;
                    end
                    acc_q <= shift_d[BCD_W+DIN_W-1:DIN_W];
                    bin_q <= shift_d[DIN_W-1:0];
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DIN_W - 1)) begin
                        state_q <= UPDATE;
                    end
                end
                UPDATE: begin
                    bcd_q  <= acc_q;
                    done_q <= 1'b1;
                    // A strobe landing here is the newest value, so it wins over the slot
                    if (ld_i || pend_vld_q) begin
                        bin_q      <= ld_i ? din_i : pend_q;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        pend_vld_q <= 1'b0;
                        state_q    <= SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bcd_o  = bcd_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/out_display_driver.sv
// Decimal readout of the output register on a multiplexed 3-digit seven-segment display.
module out_display_driver
    import out_display_driver_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 1000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [DIN_W-1:0]   din,
    input  logic               ld,
    output logic [SEG_W-1:0]   seg,
    output logic [NDIGITS-1:0] an,
    output logic [BCD_W-1:0]   bcd,
    output logic               busy,
    output logic               done
);

    logic [BCD_W-1:0]   bcd_w;
    logic [SCAN_W-1:0]  scan_q, scan_d;
    logic [DIG_W-1:0]   dig_q, dig_d;
    logic [NDIGITS-1:0] an_q, an_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic               scan_wrap;
    logic [NIB_W-1:0]   nib;
    logic               hund_zero;
    logic               tens_zero;
    logic               blank;

    bin2bcd_seq u_conv (
        .clk_i  (clk),
        .clr_i  (clr),
        .din_i  (din),
        .ld_i   (ld),
        .bcd_o  (bcd_w),
        .busy_o (busy),
        .done_o (done)
    );

    // Scan timing, digit select, leading-zero blanking and segment decode
    always_comb begin
        scan_wrap = (scan_q == SCAN_W'(REFRESH_DIV - 1));
        scan_d    = scan_wrap ? '0 : scan_q + SCAN_W'(1);
        dig_d     = dig_q;
        if (scan_wrap) begin
            dig_d = (dig_q == DIG_W'(NDIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
        end
        an_d = NDIGITS'(1) << dig_d;

        case (dig_d)
            2'd2:    nib = bcd_w[3*NIB_W-1:2*NIB_W];
            2'd1:    nib = bcd_w[2*NIB_W-1:NIB_W];
            default: nib = bcd_w[NIB_W-1:0];
        endcase

        hund_zero = (bcd_w[3*NIB_W-1:2*NIB_W] == 4'd0);
        tens_zero = (bcd_w[2*NIB_W-1:NIB_W] == 4'd0);
        blank     = BLANK_LZ && (((dig_d == 2'd2) && hund_zero) ||
                                 ((dig_d == 2'd1) && hund_zero && tens_zero));
        seg_d     = blank ? SEG_BLANK : seg_decode(nib);
    end

    // Display registers; an and seg are computed from the same next digit so they stay aligned
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            scan_q <= '0;
            dig_q  <= '0;
            an_q   <= NDIGITS'(1);
            seg_q  <= SEG_0;
        end else begin
            scan_q <= scan_d;
            dig_q  <= dig_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign bcd = bcd_w;

endmodule

// File: tb/tb_out_display_driver.sv
// Directed bench for out_display_driver: conversion timing, pending-load handling, reset and scan/blanking.
module tb_out_display_driver;

    logic        clk;
    logic        clr;
    logic [7:0]  din;
    logic        ld;

    logic [6:0]  seg_b, seg_n;
    logic [2:0]  an_b, an_n;
    logic [11:0] bcd_b, bcd_n;
    logic        busy_b, busy_n;
    logic        done_b, done_n;

    int total = 0;
    int bad   = 0;

    out_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_b (
        .clk  (clk),
        .clr  (clr),
        .din  (din),
        .ld   (ld),
        .seg  (seg_b),
        .an   (an_b),
        .bcd  (bcd_b),
        .busy (busy_b),
        .done (done_b)
    );

    out_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_n (
        .clk  (clk),
        .clr  (clr),
        .din  (din),
        .ld   (ld),
        .seg  (seg_n),
        .an   (an_n),
        .bcd  (bcd_n),
        .busy (busy_n),
        .done (done_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_bcd"},  32'(bcd_b),  32'h000);
        chk({tag, "_an"},   32'(an_b),   32'h1);
        chk({tag, "_seg"},  32'(seg_b),  32'h3F);
        chk({tag, "_busy"}, 32'(busy_b), 32'h0);
        chk({tag, "_done"}, 32'(done_b), 32'h0);
        chk({tag, "_busyn"}, 32'(busy_n), 32'h0);
    endtask

    // Load v at edge k; done and bcd must appear exactly after edge k+9
    task automatic conv(input logic [7:0] v, input logic [11:0] exp, input string tag);
        din = v;
        ld  = 1'b1;
        tick;
        ld  = 1'b0;
        chk({tag, "_busy_k"}, 32'(busy_b), 32'h1);
        repeat (8) tick;
        chk({tag, "_early_done"}, 32'(done_b), 32'h0);
        tick;
        chk({tag, "_done"},  32'(done_b), 32'h1);
        chk({tag, "_bcd"},   32'(bcd_b),  32'(exp));
        chk({tag, "_donen"}, 32'(done_n), 32'h1);
        chk({tag, "_bcdn"},  32'(bcd_n),  32'(exp));
        tick;
        chk({tag, "_done_off"}, 32'(done_b), 32'h0);
        chk({tag, "_idle"},     32'(busy_b), 32'h0);
    endtask

    // Follow one full scan round from the first cycle of the ones digit
    task automatic scan_check(input logic [6:0] b0, input logic [6:0] b1, input logic [6:0] b2,
                              input logic [6:0] n0, input logic [6:0] n1, input logic [6:0] n2,
                              input string tag);
        for (int i = 0; i < 16 && an_b !== 3'b100; i++) tick;
        chk({tag, "_sync100"}, 32'(an_b), 32'h4);
        for (int i = 0; i < 8 && an_b !== 3'b001; i++) tick;
        chk({tag, "_sync001"}, 32'(an_b), 32'h1);
        chk({tag, "_seg0"},  32'(seg_b), 32'(b0));
        chk({tag, "_segn0"}, 32'(seg_n), 32'(n0));
        repeat (3) tick;
        chk({tag, "_hold0"}, 32'(an_b), 32'h1);
        tick;
        chk({tag, "_an1"},   32'(an_b),  32'h2);
        chk({tag, "_an1n"},  32'(an_n),  32'h2);
        chk({tag, "_seg1"},  32'(seg_b), 32'(b1));
        chk({tag, "_segn1"}, 32'(seg_n), 32'(n1));
        repeat (4) tick;
        chk({tag, "_an2"},   32'(an_b),  32'h4);
        chk({tag, "_seg2"},  32'(seg_b), 32'(b2));
        chk({tag, "_segn2"}, 32'(seg_n), 32'(n2));
        repeat (4) tick;
        chk({tag, "_wrap"},  32'(an_b),  32'h1);
    endtask

    initial begin
        int ndone;
        int when;
        logic [11:0] bcd_at;

        clr = 1'b1;
        din = 8'd0;
        ld  = 1'b0;
        repeat (3) tick;
        chk_reset("rst");
        clr = 1'b0;
        tick;

        // Maximum input
        conv(8'd255, 12'h255, "c255");

        // Reset during a conversion discards it and clears the shown value
        din = 8'd200;
        ld  = 1'b1;
        tick;
        ld  = 1'b0;
        repeat (4) tick;
        clr = 1'b1;
        repeat (2) tick;
        chk_reset("midrst");
        clr = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done_b) ndone++;
        end
        chk("midrst_nodone", 32'(ndone), 32'd0);
        chk("midrst_bcd", 32'(bcd_b), 32'h000);
        conv(8'd10, 12'h010, "c10");

        // Single digit with blanking vs. full readout
        conv(8'd7, 12'h007, "c7");
        scan_check(7'h07, 7'h00, 7'h00, 7'h07, 7'h3F, 7'h3F, "s7");

        // Loads while busy: 42 is overwritten by 9 in the pending slot
        din = 8'd100;
        ld  = 1'b1;
        tick;
        ld  = 1'b0;
        repeat (2) tick;
        din = 8'd42;
        ld  = 1'b1;
        tick;
        ld  = 1'b0;
        tick;
        din = 8'd9;
        ld  = 1'b1;
        tick;
        ld  = 1'b0;
        repeat (3) tick;
        chk("pend_early", 32'(done_b), 32'h0);
        tick;
        chk("pend_done1", 32'(done_b), 32'h1);
        chk("pend_bcd1",  32'(bcd_b),  32'h100);
        chk("pend_busy",  32'(busy_b), 32'h1);
        ndone  = 0;
        when   = 0;
        bcd_at = 12'h000;
        for (int i = 1; i <= 15; i++) begin
            tick;
            if (done_b) begin
                ndone++;
                when   = i;
                bcd_at = bcd_b;
            end
        end
        chk("pend_ndone", 32'(ndone),  32'd1);
        chk("pend_when",  32'(when),   32'd9);
        chk("pend_bcd2",  32'(bcd_at), 32'h009);
        chk("pend_idle",  32'(busy_b), 32'h0);

        // Zero: only the ones digit lights when blanking
        conv(8'd0, 12'h000, "c0");
        scan_check(7'h3F, 7'h00, 7'h00, 7'h3F, 7'h3F, 7'h3F, "s0");

        // Tens shown once non-zero even with zero hundreds
        conv(8'd42, 12'h042, "c42");
        scan_check(7'h5B, 7'h66, 7'h00, 7'h5B, 7'h66, 7'h3F, "s42");

        // Embedded zero tens is never blanked when hundreds is non-zero
        conv(8'd105, 12'h105, "c105");
        scan_check(7'h6D, 7'h3F, 7'h06, 7'h6D, 7'h3F, 7'h06, "s105");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
